// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, colour type and sprite colour defaults
//
// Purpose : common definitions for the 1024x768 @ 60 Hz pixel pipeline.
// Ports   : none (package).
package vga_pkg;

    localparam int COORD_W         = 12;

    localparam int HOR_TOTAL_TIME  = 1344;
    localparam int HOR_ADDR_TIME   = 1024;
    localparam int HOR_BLANK_START = 1024;
    localparam int HOR_SYNC_START  = 1048;
    localparam int HOR_SYNC_TIME   = 136;

    localparam int VER_TOTAL_TIME  = 806;
    localparam int VER_ADDR_TIME   = 768;
    localparam int VER_BLANK_START = 768;
    localparam int VER_SYNC_START  = 771;
    localparam int VER_SYNC_TIME   = 6;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t KEY_COLOR_DEFAULT = 12'hF0F;
    localparam rgb444_t BG_COLOR_DEFAULT  = 12'h000;

    // Timing fields carried down the pixel pipeline, in bus order.
    typedef struct packed {
        logic [COORD_W-1:0] hcount;
        logic [COORD_W-1:0] vcount;
        logic               hsync;
        logic               vsync;
        logic               hblnk;
        logic               vblnk;
    } vga_timing_t;

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA timing bus without and with the rgb field
//
// Purpose : vga_if_norgb carries raw timing from the generator; vga_if adds rgb.
// Signals : hcount, vcount (12 bit), hsync, vsync, hblnk, vblnk, rgb (vga_if only).
interface vga_if_norgb;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

interface vga_if;
    logic [11:0]      hcount;
    logic [11:0]      vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    vga_pkg::rgb444_t rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/pos_latch.sv
// rtl/pos_latch.sv - double-buffered sprite position, swapped on the vblank rising edge
//
// Purpose : holds a pending position written by pos_valid and copies it to the
//           active position once per frame so the sprite never tears mid-frame.
// Ports   : clk, rst_n (async, active-low), vblnk (raw timing), pos_valid/xpos/ypos
//           (position strobe), ax/ay (active position), frame_start (1-cycle pulse).
module pos_latch
    import vga_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vblnk,
    input  logic               pos_valid,
    input  logic [COORD_W-1:0] xpos,
    input  logic [COORD_W-1:0] ypos,
    output logic [COORD_W-1:0] ax,
    output logic [COORD_W-1:0] ay,
    output logic               frame_start
);

    logic               vblnk_prev;
    logic               vblank_edge;
    logic [COORD_W-1:0] pend_x;
    logic [COORD_W-1:0] pend_y;

    assign vblank_edge = vblnk & ~vblnk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_prev  <= 1'b0;
            pend_x      <= '0;
            pend_y      <= '0;
            ax          <= '0;
            ay          <= '0;
            frame_start <= 1'b0;
        end else begin
            vblnk_prev  <= vblnk;
            frame_start <= vblank_edge;
            if (pos_valid) begin
                pend_x <= xpos;
                pend_y <= ypos;
            end
            // A strobe landing on the edge itself bypasses the pending register,
            // otherwise it would be a whole frame late.
            if (vblank_edge) begin
                ax <= pos_valid ? xpos : pend_x;
                ay <= pos_valid ? ypos : pend_y;
            end
        end
    end

endmodule

// File: rtl/draw_sprite.sv
// rtl/draw_sprite.sv - overlays a ROM sprite with colour-key transparency on the VGA stream
//
// Purpose : two-stage pixel pipeline; stage 1 computes the hit test and ROM address,
//           stage 2 muxes ROM data, background and blanking into rgb.
// Ports   : clk, rst_n (async, active-low), in (timing in), xpos/ypos/pos_valid
//           (position strobe), rom_addr/rom_data (synchronous sprite ROM),
//           out (timing delayed 2 cycles plus rgb), frame_start (position update pulse).
module draw_sprite
    import vga_pkg::*;
#(
    parameter int      SPRITE_W  = 32,
    parameter int      SPRITE_H  = 32,
    parameter rgb444_t KEY_COLOR = KEY_COLOR_DEFAULT,
    parameter rgb444_t BG_COLOR  = BG_COLOR_DEFAULT,
    localparam int     ADDR_W    = $clog2(SPRITE_W * SPRITE_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_if_norgb.in           in,
    input  logic [11:0]       xpos,
    input  logic [11:0]       ypos,
    input  logic              pos_valid,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    vga_if.out                out,
    output logic              frame_start
);

    localparam int HB = $clog2(SPRITE_W);
    localparam int VB = $clog2(SPRITE_H);

    logic [COORD_W-1:0] ax;
    logic [COORD_W-1:0] ay;

    pos_latch u_pos_latch (
        .clk         (clk),
        .rst_n       (rst_n),
        .vblnk       (in.vblnk),
        .pos_valid   (pos_valid),
        .xpos        (xpos),
        .ypos        (ypos),
        .ax          (ax),
        .ay          (ay),
        .frame_start (frame_start)
    );

    // Stage 1: hit test. The >= guards make the subtractions safe, so a sprite
    // left of or above the beam can never wrap into view.
    logic [COORD_W-1:0] hdiff;
    logic [COORD_W-1:0] vdiff;
    logic               in_sprite;
    logic [ADDR_W-1:0]  addr_next;

    assign hdiff     = in.hcount - ax;
    assign vdiff     = in.vcount - ay;
    assign in_sprite = (in.hcount >= ax) && (hdiff < COORD_W'(SPRITE_W)) &&
                       (in.vcount >= ay) && (vdiff < COORD_W'(SPRITE_H));
    // Power-of-two sizes turn row*SPRITE_W + col into a concatenation.
    assign addr_next = in_sprite ? {vdiff[VB-1:0], hdiff[HB-1:0]} : '0;

    vga_timing_t t1, t2;
    logic        in_sprite_d1, in_sprite_d2;
    logic        valid_d1, valid_d2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1           <= '0;
            t2           <= '0;
            rom_addr     <= '0;
            in_sprite_d1 <= 1'b0;
            in_sprite_d2 <= 1'b0;
            valid_d1     <= 1'b0;
            valid_d2     <= 1'b0;
        end else begin
            t1           <= {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk};
            rom_addr     <= addr_next;
            in_sprite_d1 <= in_sprite;
            valid_d1     <= 1'b1;
            t2           <= t1;
            in_sprite_d2 <= in_sprite_d1;
            valid_d2     <= valid_d1;
        end
    end

    // Stage 2: the ROM registers rom_addr itself, so its data lines up with t2
    // in the same cycle; rgb is therefore a mux on the ROM output rather than
    // another register. valid_d2 keeps rgb at zero while reset is asserted and
    // until the pipeline has filled.
    logic [11:0] rgb;

    always_comb begin
        rgb = 12'h000;
        if (!valid_d2 || t2.hblnk || t2.vblnk) begin
            rgb = 12'h000;
        end else if (in_sprite_d2 && (rom_data != KEY_COLOR)) begin
            rgb = rom_data;
        end else begin
            rgb = BG_COLOR;
        end
    end

    assign out.hcount = t2.hcount;
    assign out.vcount = t2.vcount;
    assign out.hsync  = t2.hsync;
    assign out.vsync  = t2.vsync;
    assign out.hblnk  = t2.hblnk;
    assign out.vblnk  = t2.vblnk;
    assign out.rgb    = rgb;

endmodule

// File: tb/tb_draw_sprite.sv
// tb/tb_draw_sprite.sv - self-checking bench for draw_sprite
module tb_draw_sprite;

    localparam logic [11:0] KEY = 12'hF0F;
    localparam logic [11:0] BG  = 12'h00A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] xpos, ypos;
    logic        pos_valid;
    logic [9:0]  rom_addr;
    logic [11:0] rom_data;
    logic        frame_start;

    vga_if_norgb vin();
    vga_if       vout();

    always #5 clk = ~clk;

    draw_sprite #(
        .SPRITE_W  (32),
        .SPRITE_H  (32),
        .KEY_COLOR (KEY),
        .BG_COLOR  (BG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (vin),
        .xpos        (xpos),
        .ypos        (ypos),
        .pos_valid   (pos_valid),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .out         (vout),
        .frame_start (frame_start)
    );

    // Sprite ROM: word 33 holds the key colour, every other word is 0x100|addr.
    function automatic logic [11:0] rom_fn(input logic [9:0] a);
        return (a == 10'd33) ? KEY : (12'h100 | {2'b00, a});
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    typedef struct {
        logic [11:0] h;
        logic [11:0] v;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic [9:0]  addr;
        logic        en;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   fs_cnt = 0;
    int   m_ax   = 0;
    int   m_ay   = 0;
    exp_t hist0, hist1, hist2;
    exp_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int h, input int v, input logic hb,
                                input logic [11:0] rgb, input int addr);
        exp_t e;
        e.h = 12'(h); e.v = 12'(v); e.hb = hb; e.vb = 1'b0;
        e.rgb = rgb; e.addr = 10'(addr); e.en = 1'b1;
        return e;
    endfunction

    function automatic exp_t model(input int h, input int v, input logic hb, input logic vb);
        exp_t        e;
        bit          hit;
        int          a;
        logic [11:0] d;
        hit = (h >= m_ax) && (h - m_ax < 32) && (v >= m_ay) && (v - m_ay < 32);
        a   = hit ? (v - m_ay) * 32 + (h - m_ax) : 0;
        d   = rom_fn(10'(a));
        e.h = 12'(h); e.v = 12'(v); e.hb = hb; e.vb = vb;
        e.addr = 10'(a);
        e.rgb  = (hb || vb) ? 12'h000 : ((hit && d != KEY) ? d : BG);
        e.en   = 1'b1;
        return e;
    endfunction

    function automatic logic [63:0] out_vec();
        return 64'({vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                    vout.hblnk, vout.vblnk, vout.rgb});
    endfunction

    // One pixel cycle: drive, then at mid-cycle check rom_addr against the
    // previous pixel and the out bus against the pixel two cycles back.
    task automatic tick_e(input exp_t e, input logic pv, input logic [11:0] px, input logic [11:0] py);
        @(posedge clk);
        #1;
        vin.hcount = e.h;
        vin.vcount = e.v;
        vin.hsync  = e.h[0];
        vin.vsync  = e.v[0];
        vin.hblnk  = e.hb;
        vin.vblnk  = e.vb;
        pos_valid  = pv;
        xpos       = px;
        ypos       = py;
        hist2 = hist1;
        hist1 = hist0;
        hist0 = e;
        @(negedge clk);
        if (hist1.en) check("rom_addr", 64'(rom_addr), 64'(hist1.addr));
        if (hist2.en)
            check("out_bus", out_vec(),
                  64'({hist2.h, hist2.v, hist2.h[0], hist2.v[0], hist2.hb, hist2.vb, hist2.rgb}));
        fs_cnt += int'(frame_start);
    endtask

    task automatic tick(input int h, input int v, input logic hb, input logic vb,
                        input logic pv, input logic [11:0] px, input logic [11:0] py);
        tick_e(model(h, v, hb, vb), pv, px, py);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1100, 0, 1'b1, 1'b0, 1'b0, 12'h7FF, 12'h7FF);
    endtask

    task automatic strobe(input logic [11:0] x, input logic [11:0] y);
        tick(1100, 0, 1'b1, 1'b0, 1'b1, x, y);
    endtask

    // Vertical blank of a few cycles; optionally strobes on the rising edge itself.
    task automatic vblank(input logic pv, input logic [11:0] px, input logic [11:0] py,
                          input int new_x, input int new_y);
        int f0;
        f0   = fs_cnt;
        m_ax = new_x;
        m_ay = new_y;
        tick(1100, 770, 1'b1, 1'b1, pv, px, py);
        repeat (3) tick(1100, 770, 1'b1, 1'b1, 1'b0, 12'h7FF, 12'h7FF);
        idle(3);
        check("frame_start_pulses", 64'(fs_cnt - f0), 64'd1);
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        for (int v = y0; v <= y1; v++)
            for (int h = x0; h <= x1; h++)
                tick(h, v, h >= 1024, v >= 768, 1'b0, 12'h7FF, 12'h7FF);
    endtask

    task automatic clear_hist();
        hist0.en = 1'b0; hist1.en = 1'b0; hist2.en = 1'b0;
    endtask

    initial begin
        int f0;

        tbl[0]  = mk(100, 50, 1'b0, 12'h100, 0);
        tbl[1]  = mk(131, 50, 1'b0, 12'h11F, 31);
        tbl[2]  = mk(132, 50, 1'b0, BG,      0);
        tbl[3]  = mk( 99, 50, 1'b0, BG,      0);
        tbl[4]  = mk(100, 81, 1'b0, 12'h3E0, 992);
        tbl[5]  = mk(100, 82, 1'b0, BG,      0);
        tbl[6]  = mk(131, 81, 1'b0, 12'h3FF, 1023);
        tbl[7]  = mk(101, 51, 1'b0, BG,      33);
        tbl[8]  = mk(110, 60, 1'b1, 12'h000, 330);
        tbl[9]  = mk(110, 60, 1'b0, 12'h14A, 330);
        tbl[10] = mk(  0,  0, 1'b0, BG,      0);
        tbl[11] = mk(115, 70, 1'b0, 12'h38F, 655);

        clear_hist();
        rst_n      = 1'b0;
        vin.hcount = 12'd100; vin.vcount = 12'd50;
        vin.hsync  = 1'b1;    vin.vsync  = 1'b1;
        vin.hblnk  = 1'b0;    vin.vblnk  = 1'b1;
        pos_valid  = 1'b1;    xpos = 12'h123; ypos = 12'h045;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({out_vec()[39:0], rom_addr, frame_start}), 64'd0);
        pos_valid = 1'b0;
        vin.vblnk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // First position, applied on the first vblank edge.
        f0 = fs_cnt;
        strobe(12'd100, 12'd50);
        idle(2);
        check("no_fs_before_vblank", 64'(fs_cnt - f0), 64'd0);
        vblank(1'b0, 12'h7FF, 12'h7FF, 100, 50);

        for (int i = 0; i < 12; i++) tick_e(tbl[i], 1'b0, 12'h7FF, 12'h7FF);
        idle(2);

        scan(96, 135, 48, 83);

        // Mid-frame strobe stays pending until vblank.
        f0 = fs_cnt;
        tick(100, 49, 1'b0, 1'b0, 1'b1, 12'd200, 12'd50);
        scan(96, 135, 50, 51);
        scan(196, 235, 50, 50);
        check("no_fs_mid_frame", 64'(fs_cnt - f0), 64'd0);
        vblank(1'b0, 12'h7FF, 12'h7FF, 200, 50);
        scan(96, 104, 50, 50);
        scan(196, 235, 50, 51);

        // Strobe coinciding with the vblank edge takes effect immediately.
        vblank(1'b1, 12'd300, 12'd50, 300, 50);
        scan(196, 204, 50, 50);
        scan(296, 335, 50, 51);

        // Right-edge clipping.
        strobe(12'd1020, 12'd0);
        vblank(1'b0, 12'h7FF, 12'h7FF, 1020, 0);
        scan(1010, 1030, 0, 1);

        // Beyond the horizontal total: nothing drawn.
        strobe(12'd1400, 12'd0);
        vblank(1'b0, 12'h7FF, 12'h7FF, 1400, 0);
        scan(0, 40, 0, 1);
        scan(1018, 1030, 0, 0);

        // Asynchronous reset in the middle of a line.
        scan(100, 110, 10, 10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({out_vec()[39:0], rom_addr, frame_start}), 64'd0);
        @(negedge clk);
        check("reset_hold_outputs", 64'({out_vec()[39:0], rom_addr, frame_start}), 64'd0);
        rst_n = 1'b1;
        clear_hist();
        m_ax = 0;
        m_ay = 0;
        f0   = fs_cnt;
        idle(4);
        check("no_fs_after_reset", 64'(fs_cnt - f0), 64'd0);
        vblank(1'b0, 12'h7FF, 12'h7FF, 0, 0);
        scan(0, 40, 0, 1);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_sprite.md
DRAW_SPRITE -- requirements
Module: draw_sprite

Interface
REQ-001 The block SHALL have parameter SPRITE_W, default 32, meaning sprite width in pixels (power of two).
REQ-002 The block SHALL have parameter SPRITE_H, default 32, meaning sprite height in pixels (power of two).
REQ-003 The block SHALL have parameter KEY_COLOR, default 12'hF0F, meaning the transparent ROM colour.
REQ-004 The block SHALL have parameter BG_COLOR, default 12'h000, meaning the active-area background colour.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the pixel clock; it is the only clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit, meaning the reset, asynchronous and active-low.
REQ-007 The block SHALL have port in, a vga_if_norgb.in modport, meaning hcount/vcount/hsync/vsync/hblnk/vblnk from the timing generator.
REQ-008 The block SHALL have port xpos, input, 12 bits, meaning the requested sprite left edge.
REQ-009 The block SHALL have port ypos, input, 12 bits, meaning the requested sprite top edge.
REQ-010 The block SHALL have port pos_valid, input, 1 bit, meaning a one-cycle strobe that captures xpos/ypos.
REQ-011 The block SHALL have port rom_addr, output, log2(SPRITE_W*SPRITE_H) bits, meaning the sprite ROM address.
REQ-012 The block SHALL have port rom_data, input, 12 bits, meaning ROM RGB444 data, valid one cycle after rom_addr.
REQ-013 The block SHALL have port out, a vga_if.out modport, meaning delayed timing plus the rgb field.
REQ-014 The block SHALL have port frame_start, output, 1 bit, meaning a one-cycle pulse when the active position updates.

Function
REQ-015 A pos_valid strobe SHALL load xpos/ypos into a pending register; a later strobe SHALL overwrite it.
REQ-016 A vblank edge SHALL be detected on the cycle in.vblnk=1 while the registered previous vblnk=0.
REQ-017 On a vblank edge, the pending position SHALL be copied to the active position and frame_start SHALL pulse high for exactly one cycle.
REQ-018 When pos_valid and a vblank edge coincide, the new xpos/ypos SHALL reach the active position on that same edge (bypass).
REQ-019 Stage 1 SHALL compute in_sprite = (hcount>=ax) && (hcount-ax<SPRITE_W) && (vcount>=ay) && (vcount-ay<SPRITE_H), using 12-bit unsigned arithmetic with no wrap-around.
REQ-020 Stage 1 SHALL register rom_addr = (vcount-ay)*SPRITE_W + (hcount-ax), truncated to the address width, and SHALL hold 0 when not in_sprite.
REQ-021 All in fields SHALL be delayed by exactly 2 cycles to out; the rgb field SHALL align with the same delayed hcount/vcount.
REQ-022 Stage 2 rgb SHALL be 12'h000 when the delayed hblnk or vblnk is 1.
REQ-023 Otherwise, stage 2 rgb SHALL be rom_data if the delayed in_sprite is 1 and rom_data != KEY_COLOR, else BG_COLOR.
REQ-024 A sprite partly past the right or bottom edge SHALL be clipped; ax>=HOR_TOTAL_TIME SHALL draw nothing.

Reset
REQ-025 While rst_n=0, all out fields, rom_addr, frame_start, the pipeline registers, the pending and active positions, and the previous-vblnk register SHALL be 0.
REQ-026 Assertion of rst_n mid-line SHALL clear state immediately; after release, the first frame_start SHALL occur on the next detected vblank edge.

Structure
REQ-027 KEY_COLOR and BG_COLOR defaults, plus the RGB444 colour typedef, SHALL live in vga_pkg alongside the existing timing constants.
REQ-028 The position double-buffer with vblank-edge detect SHALL be a sub-module named pos_latch; the datapath SHALL stay in draw_sprite.

Verification
REQ-029 Bench shall cover: xpos=100, ypos=50 strobed before vblank, then a full frame -> out.rgb=ROM pixels for hcount 100..131 and vcount 50..81, BG_COLOR elsewhere in the active area.
REQ-030 Bench shall cover: in.hcount=100, vcount=50 at cycle t -> rom_addr=0 at t+1, and out.hcount=100 with the matching rgb at t+2.
REQ-031 Bench shall cover: ROM word=12'hF0F inside the sprite -> out.rgb=BG_COLOR; in.hblnk=1 -> out.rgb=12'h000.
REQ-032 Bench shall cover: pos_valid with xpos=200 mid-frame -> the sprite stays at the old x until vblank; frame_start pulses once, and the next frame draws at 200.
REQ-033 Bench shall cover: pos_valid coinciding with the vblank edge, xpos=300 -> the next frame draws at 300.
REQ-034 Bench shall cover: xpos=1020 -> only columns 1020..1023 drawn; rst_n pulsed low mid-line -> all outputs 0 asynchronously, and the sprite reappears at (0,0) after the next vblank.
